// File: rtl/seven_seg_scan_ctrl.sv
// Multi-digit 7-segment driver: serial shift-add-3 binary-to-BCD conversion with a
// load/busy/done handshake and a time-multiplexed anode scan. Define SEG_LZB_EN for leading-zero blanking.
module seven_seg_scan_ctrl #(
    parameter int NUM_W    = 13,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 262144
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [NUM_W-1:0]  num,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        led_out
);

    localparam int SH_W  = 4 * DIGITS;
    localparam int CNT_W = $clog2(NUM_W + 1);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

    state_t            r_state;
    logic [NUM_W-1:0]  r_shift;
    logic [SH_W-1:0]   r_shadow;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic [SH_W-1:0]   r_disp;
    logic              r_overflow;
    logic              r_busy;
    logic              r_done;
    logic [PRE_W-1:0]  r_pre;
    logic [IDX_W-1:0]  r_idx;
    logic [DIGITS-1:0] r_anode;
    logic [6:0]        r_led;

    logic [SH_W-1:0]   w_adj;
    logic [3:0]        w_digit;
    logic [DIGITS-1:0] w_anode;
    logic [6:0]        w_seg;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b0000001;
        endcase
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        w_adj = r_shadow;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_shadow[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_shadow[4*i +: 4] + 4'd3;
        end
    end

    // Digit index 0 is the leftmost (most significant) nibble of the display register.
`ifdef SEG_LZB_EN
    logic w_allz;
    logic w_blank;
`endif
    always_comb begin
        w_digit = 4'd0;
        w_anode = '1;
`ifdef SEG_LZB_EN
        w_allz  = 1'b1;
        w_blank = 1'b0;
`endif
        for (int k = 0; k < DIGITS; k++) begin
`ifdef SEG_LZB_EN
            w_allz = w_allz & (r_disp[4*(DIGITS-1-k) +: 4] == 4'd0);
`endif
            if (r_idx == IDX_W'(k)) begin
                w_digit             = r_disp[4*(DIGITS-1-k) +: 4];
                w_anode[DIGITS-1-k] = 1'b0;
`ifdef SEG_LZB_EN
                w_blank             = w_allz && (k != DIGITS - 1);
`endif
            end
        end
        if (r_overflow) begin
            w_seg = 7'b1111110;
        end else begin
`ifdef SEG_LZB_EN
            w_seg = w_blank ? 7'b1111111 : seg7(w_digit);
`else
            w_seg = seg7(w_digit);
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_shadow   <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_disp     <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_shift  <= num;
                        r_shadow <= '0;
                        r_cnt    <= CNT_W'(NUM_W);
                        r_ovf    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_shadow <= {w_adj[SH_W-2:0], r_shift[NUM_W-1]};
                    r_shift  <= r_shift << 1;
                    r_ovf    <= r_ovf | w_adj[SH_W-1];
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_disp     <= r_shadow;
                    r_overflow <= r_ovf;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Scan runs freely; load/commit never disturb its position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_anode <= '1;
            r_led   <= 7'b1111111;
        end else begin
            r_anode <= w_anode;
            r_led   <= w_seg;
            if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
                r_pre <= '0;
                r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign anode    = r_anode;
    assign led_out  = r_led;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: a 4-digit and a 3-digit instance (SCAN_DIV=4)
// share stimulus; expected segment patterns are hand-written constants.
module tb_seven_seg_scan_ctrl;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                           S3 = 7'b0000110, S4 = 7'b1001100, S7 = 7'b0001111,
                           S8 = 7'b0000000, S9 = 7'b0000100, SD = 7'b1111110,
                           SB = 7'b1111111;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [12:0] num;
    logic        busy4, done4, ovf4, busy3, done3, ovf3;
    logic [3:0]  anode4;
    logic [2:0]  anode3;
    logic [6:0]  led4, led3;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    seven_seg_scan_ctrl #(.NUM_W(13), .DIGITS(4), .SCAN_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .num(num),
        .busy(busy4), .done(done4), .overflow(ovf4), .anode(anode4), .led_out(led4)
    );

    seven_seg_scan_ctrl #(.NUM_W(13), .DIGITS(3), .SCAN_DIV(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .load(load), .num(num),
        .busy(busy3), .done(done3), .overflow(ovf3), .anode(anode3), .led_out(led3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/anode4"}, 32'(anode4), 32'hF);
        check({tag, "/led4"},   32'(led4),   32'h7F);
        check({tag, "/busy4"},  32'(busy4),  32'h0);
        check({tag, "/done4"},  32'(done4),  32'h0);
        check({tag, "/ovf4"},   32'(ovf4),   32'h0);
        check({tag, "/ovf3"},   32'(ovf3),   32'h0);
    endtask

    // e4[k]/e3[k] are the segment patterns expected while digit index k (0 = leftmost) is lit.
    task automatic check_scan(input string tag, input logic [3:0][6:0] e4, input logic [2:0][6:0] e3);
        logic [3:0] exp_an4;
        logic [2:0] exp_an3;
        int i4, i3;
        for (int t = 0; t < 16; t++) begin
            tick();
            i4 = ((cyc - 1) / 4) % 4;
            i3 = ((cyc - 1) / 4) % 3;
            exp_an4 = ~(4'b1000 >> i4);
            exp_an3 = ~(3'b100 >> i3);
            check({tag, "/anode4"}, 32'(anode4), 32'(exp_an4));
            check({tag, "/led4"},   32'(led4),   32'(e4[i4]));
            check({tag, "/anode3"}, 32'(anode3), 32'(exp_an3));
            check({tag, "/led3"},   32'(led3),   32'(e3[i3]));
        end
    endtask

    // Loads v and checks busy/done over the whole handshake; optionally pokes load
    // mid-conversion (CONV) and at the commit cycle with a different num.
    task automatic do_load(input string tag, input logic [12:0] v, input bit poke);
        load = 1'b1;
        num  = v;
        tick();
        load = 1'b0;
        check({tag, "/busy_k0"}, 32'(busy4), 32'h1);
        check({tag, "/done_k0"}, 32'(done4), 32'h0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            load = 1'b0;
            check($sformatf("%s/busy_k%0d", tag, k), 32'(busy4), 32'(k <= 13));
            check($sformatf("%s/done_k%0d", tag, k), 32'(done4), 32'(k == 14));
            if (k == 14) check({tag, "/done3"}, 32'(done3), 32'h1);
            if (poke && (k == 4 || k == 13)) begin
                load = 1'b1;
                num  = 13'd42;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        num   = '0;
        cyc   = 0;
        tick();
        tick();
        check_reset_outputs("reset");
        check("reset/anode3", 32'(anode3), 32'h7);

        rst_n = 1'b1;
        tick();
        check("release/anode4", 32'(anode4), 32'h7);
        check("release/led4",   32'(led4),   32'(S0));

        // 1234 with a second load (42) attempted during CONV and at COMMIT.
        do_load("ld1234", 13'd1234, 1'b1);
        check("ld1234/ovf4", 32'(ovf4), 32'h0);
        check("ld1234/ovf3", 32'(ovf3), 32'h1);
        check_scan("scan1234", {S4, S3, S2, S1}, {SD, SD, SD});

        do_load("ld8191", 13'd8191, 1'b0);
        check("ld8191/ovf4", 32'(ovf4), 32'h0);
        check("ld8191/ovf3", 32'(ovf3), 32'h1);
        check_scan("scan8191", {S1, S9, S1, S8}, {SD, SD, SD});

        // Reset asserted after CONV cycle 5.
        load = 1'b1;
        num  = 13'd1234;
        tick();
        load = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0;
        cyc   = 0;
        #1;
        check_reset_outputs("midrst");
        tick();
        check_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("midrst/done_%0d", k), 32'(done4), 32'h0);
            check($sformatf("midrst/busy_%0d", k), 32'(busy4), 32'h0);
        end
`ifdef SEG_LZB_EN
        check_scan("scan_zero", {S0, SB, SB, SB}, {S0, SB, SB});
`else
        check_scan("scan_zero", {S0, S0, S0, S0}, {S0, S0, S0});
`endif

        do_load("ld7", 13'd7, 1'b0);
        check("ld7/ovf4", 32'(ovf4), 32'h0);
        check("ld7/ovf3", 32'(ovf3), 32'h0);
`ifdef SEG_LZB_EN
        check_scan("scan7", {S7, SB, SB, SB}, {S7, SB, SB});
`else
        check_scan("scan7", {S7, S0, S0, S0}, {S7, S0, S0});
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
